// File: rtl/display_input_scanner.sv
// Button chain scanner, debouncer and quadrature dial decoder on Avalon-MM.
// Ports: clk/reset_n, shift_* chain pins, dial_quad, avs_* slave, irq.
`timescale 1ns/1ps
module display_input_scanner #(
    parameter int NUM_BUTTONS = 16,
    parameter int NUM_DIALS   = 2,
    parameter int CLK_DIV     = 25,
    parameter int DEBOUNCE    = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   shift_clkin,
    output logic                   shift_load,
    input  logic                   shift_out,
    input  logic [2*NUM_DIALS-1:0] dial_quad,
    input  logic [3:0]             avs_address,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    output logic                   irq
);
    localparam int NB    = NUM_BUTTONS;
    localparam int CW    = COUNT_WIDTH;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT_HI, S_SHIFT_LO, S_DONE
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    state_t           r_state, w_state_nx;
    logic             r_shift_load, w_load_nx;
    logic             r_shift_clkin, w_clk_nx;
    logic             w_sample, w_done, w_last;
    logic             r_ld;
    logic [BIT_W-1:0] r_nbits;
    logic [NB-1:0]    r_sreg, w_snap;
    logic [NB-1:0]    r_btn, r_events, w_accept, w_rise, w_ev_clr;
    logic [3:0]       r_dbc [NB];
    logic [31:0]      r_scan_cnt;
    logic             r_irq_en, r_irq;
    logic [31:0]      r_rdata, w_rdata;
    logic [2*NUM_DIALS-1:0] r_q1, r_sync, r_prev;
    logic [NUM_DIALS-1:0][CW-1:0] w_dial;
    logic             w_unused;

    // Asynchronous assertion, release synchronised to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)    r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + DIV_W'(1);
    end

    assign w_last = (r_nbits == BIT_W'(NB - 1));

    always_comb begin
        w_state_nx = r_state;
        w_load_nx  = r_shift_load;
        w_clk_nx   = r_shift_clkin;
        w_sample   = 1'b0;
        w_done     = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nx = S_LOAD;
                    w_load_nx  = 1'b0;
                end
                S_LOAD: begin
                    // Second load tick: release load, bit NB-1 is already on shift_out.
                    if (r_ld) begin
                        w_load_nx  = 1'b1;
                        w_sample   = 1'b1;
                        w_state_nx = (NB == 1) ? S_DONE : S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    w_clk_nx   = 1'b1;
                    w_state_nx = S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    w_clk_nx   = 1'b0;
                    w_sample   = 1'b1;
                    w_state_nx = w_last ? S_DONE : S_SHIFT_HI;
                end
                S_DONE: begin
                    w_done     = 1'b1;
                    w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_IDLE;
            r_shift_load  <= 1'b1;
            r_shift_clkin <= 1'b0;
            r_ld          <= 1'b0;
            r_nbits       <= '0;
            r_sreg        <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_shift_load  <= w_load_nx;
            r_shift_clkin <= w_clk_nx;
            if (w_tick && r_state == S_LOAD) r_ld <= ~r_ld;
            if (w_sample) begin
                r_sreg  <= NB'({r_sreg, shift_out});
                r_nbits <= (r_state == S_LOAD) ? BIT_W'(1)
                                               : r_nbits + BIT_W'(1);
            end
        end
    end

    // Chain is active-low.
    assign w_snap = ~r_sreg;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NB; i++)
            w_accept[i] = w_done && (w_snap[i] != r_btn[i]) &&
                          (r_dbc[i] == 4'(DEBOUNCE - 1));
    end
    assign w_rise   = w_accept & w_snap;
    assign w_ev_clr = (avs_write && avs_address == 4'd1)
                    ? avs_writedata[NB-1:0] : '0;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn    <= '0;
            r_events <= '0;
            for (int i = 0; i < NB; i++) r_dbc[i] <= 4'd0;
        end else begin
            r_btn    <= (r_btn & ~w_accept) | (w_snap & w_accept);
            // New press beats a simultaneous clear.
            r_events <= (r_events & ~w_ev_clr) | w_rise;
            if (w_done)
                for (int i = 0; i < NB; i++)
                    r_dbc[i] <= (w_snap[i] == r_btn[i] || w_accept[i])
                              ? 4'd0 : r_dbc[i] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_q1   <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_q1   <= dial_quad;
            r_sync <= r_q1;
            r_prev <= r_sync;
        end
    end

    for (genvar d = 0; d < NUM_DIALS; d++) begin : g_dial
        logic [1:0]    w_pp, w_pc, w_df;
        logic          w_wr;
        logic [CW-1:0] r_cnt;
        // Gray {B,A} to linear position 0..3.
        assign w_pp = {r_prev[2*d+1], ^r_prev[2*d +: 2]};
        assign w_pc = {r_sync[2*d+1], ^r_sync[2*d +: 2]};
        assign w_df = w_pc - w_pp;
        assign w_wr = avs_write && (avs_address == 4'(4 + d));
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n)           r_cnt <= '0;
            else if (w_wr)          r_cnt <= avs_writedata[CW-1:0];
            else if (w_df == 2'd1)  r_cnt <= r_cnt + CW'(1);
            else if (w_df == 2'd3)  r_cnt <= r_cnt - CW'(1);
        end
        assign w_dial[d] = r_cnt;
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            4'd0: w_rdata = 32'(r_btn);
            4'd1: w_rdata = 32'(r_events);
            4'd2: w_rdata = {31'd0, r_irq_en};
            4'd3: w_rdata = r_scan_cnt;
            default: begin
                for (int d = 0; d < NUM_DIALS; d++)
                    if (avs_address == 4'(4 + d))
                        w_rdata = 32'($signed(w_dial[d]));
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_scan_cnt <= '0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_done) r_scan_cnt <= r_scan_cnt + 32'd1;
            if (avs_write && avs_address == 4'd2) r_irq_en <= avs_writedata[0];
            r_irq <= r_irq_en & (|r_events);
            if (avs_read) r_rdata <= w_rdata;
        end
    end

    assign shift_load   = r_shift_load;
    assign shift_clkin  = r_shift_clkin;
    assign avs_readdata = r_rdata;
    assign irq          = r_irq;
    assign w_unused     = ^avs_writedata;
endmodule
